ram_responder: RTL and testbench

Memory-side responder for the cache's miss/propagation port. It accepts one request at a time on the `prop_*` signals the cache drives, performs it against an internal word-addressed memory, and after a fixed latency returns one aligned block on `ram_valid`/`ram_data`. It is the cache's backing store in block-level simulation and the reference model for the RAM interface.

---
 rtl/ram_responder.sv | 148 ++++++++++++++
 tb/tb_ram_responder.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/ram_responder.sv
// Memory-side responder for the cache miss/propagation port: accepts one request at a time
// and returns one aligned block a fixed number of cycles later.
module ram_responder #(
    parameter int unsigned RAM_ADDRESS_BITS = 32,
    parameter int unsigned DATA_BITS        = 32,
    parameter int unsigned BLOCK_BITS       = 2,
    parameter int unsigned MEM_ADDR_BITS    = 10,
    parameter int unsigned LATENCY          = 3,
    parameter int unsigned COUNT_BITS       = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [RAM_ADDRESS_BITS-1:0] prop_address,
    input  logic                        prop_read_en,
    input  logic                        prop_write_en,
    input  logic [DATA_BITS-1:0]        prop_write_data,
    output logic                        ram_valid,
    output logic [DATA_BITS-1:0]        ram_data [BLOCK_BITS-1:0],
    output logic                        busy,
    output logic [COUNT_BITS-1:0]       read_count,
    output logic [COUNT_BITS-1:0]       write_count
);

    localparam int unsigned MEM_WORDS = 2 ** MEM_ADDR_BITS;
    localparam int unsigned CNT_W     = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [MEM_ADDR_BITS-1:0] BLK_MASK = MEM_ADDR_BITS'(BLOCK_BITS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [DATA_BITS-1:0]     mem [MEM_WORDS] = '{default: '0};
    logic [1:0]               state;
    logic [1:0]               next_state;
    logic [CNT_W-1:0]         cnt;
    logic [CNT_W-1:0]         next_cnt;
    logic [MEM_ADDR_BITS-1:0] addr_q;
    logic [MEM_ADDR_BITS-1:0] idx;
    logic [MEM_ADDR_BITS-1:0] rd_base;
    logic                     accept;
    logic                     capture;
    logic                     do_write;
    logic [DATA_BITS-1:0]     blk_word [BLOCK_BITS-1:0];

    assign idx = prop_address[MEM_ADDR_BITS-1:0];

    // Upper address bits alias onto the same words by design.
    generate
        if (RAM_ADDRESS_BITS > MEM_ADDR_BITS) begin : g_alias
            logic unused_addr_bits;
            assign unused_addr_bits = ^prop_address[RAM_ADDRESS_BITS-1:MEM_ADDR_BITS];
        end
    endgenerate

    // State and countdown register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    // Next-state logic; capture marks the edge that enters RESP.
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        accept     = 1'b0;
        capture    = 1'b0;
        case (state)
            S_IDLE: begin
                if (prop_read_en | prop_write_en) begin
                    accept = 1'b1;
                    if (LATENCY == 1) begin
                        next_state = S_RESP;
                        capture    = 1'b1;
                    end else begin
                        next_state = S_BUSY;
                        next_cnt   = CNT_W'(LATENCY - 1);
                    end
                end
            end
            S_BUSY: begin
                if (cnt == CNT_W'(1)) begin
                    next_state = S_RESP;
                    next_cnt   = '0;
                    capture    = 1'b1;
                end else begin
                    next_cnt = cnt - CNT_W'(1);
                end
            end
            S_RESP:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    assign do_write = accept & prop_write_en & ~reset;
    assign rd_base  = ((state == S_IDLE) ? idx : addr_q) & ~BLK_MASK;

    // Block read; forwards a same-edge write so a single-cycle latency still sees the new word.
    always_comb begin
        for (int i = 0; i < int'(BLOCK_BITS); i++) begin
            blk_word[i] = mem[rd_base + MEM_ADDR_BITS'(i)];
            if (do_write && (idx == rd_base + MEM_ADDR_BITS'(i))) begin
                blk_word[i] = prop_write_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[idx] <= prop_write_data;
        end
    end

    // Registered outputs, address latch and statistics.
    always_ff @(posedge clk) begin
        if (reset) begin
            ram_valid   <= 1'b0;
            busy        <= 1'b0;
            addr_q      <= '0;
            read_count  <= '0;
            write_count <= '0;
            for (int i = 0; i < int'(BLOCK_BITS); i++) begin
                ram_data[i] <= '0;
            end
        end else begin
            ram_valid <= (next_state == S_RESP);
            busy      <= (next_state != S_IDLE);
            if (accept) begin
                addr_q <= idx;
                if (prop_write_en) begin
                    write_count <= write_count + COUNT_BITS'(1);
                end else begin
                    read_count <= read_count + COUNT_BITS'(1);
                end
            end
            if (capture) begin
                for (int i = 0; i < int'(BLOCK_BITS); i++) begin
                    ram_data[i] <= blk_word[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_responder.sv
// Directed self-checking bench for ram_responder with default parameters.
module tb_ram_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] prop_address;
    logic        prop_read_en;
    logic        prop_write_en;
    logic [31:0] prop_write_data;
    logic        ram_valid;
    logic [31:0] ram_data [1:0];
    logic        busy;
    logic [15:0] read_count;
    logic [15:0] write_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ram_responder dut (
        .clk             (clk),
        .reset           (reset),
        .prop_address    (prop_address),
        .prop_read_en    (prop_read_en),
        .prop_write_en   (prop_write_en),
        .prop_write_data (prop_write_data),
        .ram_valid       (ram_valid),
        .ram_data        (ram_data),
        .busy            (busy),
        .read_count      (read_count),
        .write_count     (write_count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, " ram_valid"}, ram_valid, 0);
        check({tag, " busy"}, busy, 0);
        check({tag, " data0"}, ram_data[0], 0);
        check({tag, " data1"}, ram_data[1], 0);
        check({tag, " read_count"}, read_count, 0);
        check({tag, " write_count"}, write_count, 0);
    endtask

    // One request held until ram_valid, then dropped; checks latency and return to idle.
    task automatic xact(input logic [31:0] addr, input logic rd, input logic we,
                        input logic [31:0] wd, input string tag);
        int n;
        prop_address    = addr;
        prop_read_en    = rd;
        prop_write_en   = we;
        prop_write_data = wd;
        n = 0;
        do begin
            tick();
            n++;
        end while (!ram_valid && n < 10);
        check({tag, " latency"}, n, 3);
        prop_read_en  = 1'b0;
        prop_write_en = 1'b0;
        tick();
        check({tag, " idle busy"}, busy, 0);
        check({tag, " idle valid"}, ram_valid, 0);
    endtask

    initial begin
        logic [11:0] vmask;
        int          busy_low;
        int          nvalid;

        reset           = 1'b1;
        prop_address    = '0;
        prop_read_en    = 1'b0;
        prop_write_en   = 1'b0;
        prop_write_data = '0;
        do_reset();
        check_zero("reset");

        // Read of zeroed memory.
        xact(32'h0, 1'b1, 1'b0, 32'h0, "rd0");
        check("rd0 data0", ram_data[0], 0);
        check("rd0 data1", ram_data[1], 0);
        check("rd0 read_count", read_count, 1);
        check("rd0 write_count", write_count, 0);

        // Aliasing of upper address bits.
        do_reset();
        xact(32'h10000, 1'b0, 1'b1, 32'h45, "wr_alias");
        check("wr_alias data0", ram_data[0], 32'h45);
        check("wr_alias data1", ram_data[1], 0);
        xact(32'h20000, 1'b1, 1'b0, 32'h0, "rd_alias");
        check("rd_alias data0", ram_data[0], 32'h45);
        check("rd_alias write_count", write_count, 1);
        check("rd_alias read_count", read_count, 1);

        // Two words in one block, read from either address.
        xact(32'd10, 1'b0, 1'b1, 32'h55, "wr10");
        xact(32'd11, 1'b0, 1'b1, 32'hFAFA, "wr11");
        check("wr11 data0", ram_data[0], 32'h55);
        check("wr11 data1", ram_data[1], 32'hFAFA);
        xact(32'd10, 1'b1, 1'b0, 32'h0, "rd10");
        check("rd10 data0", ram_data[0], 32'h55);
        check("rd10 data1", ram_data[1], 32'hFAFA);
        xact(32'd11, 1'b1, 1'b0, 32'h0, "rd11");
        check("rd11 data0", ram_data[0], 32'h55);
        check("rd11 data1", ram_data[1], 32'hFAFA);

        // Read held high: pulses after edges 3, 7, 11; busy low after edges 4 and 8.
        prop_address = 32'd10;
        prop_read_en = 1'b1;
        vmask    = '0;
        busy_low = 0;
        for (int s = 1; s <= 11; s++) begin
            tick();
            vmask[s] = ram_valid;
            if (!busy) busy_low++;
        end
        prop_read_en = 1'b0;
        check("held valid pattern", vmask, 12'h888);
        check("held busy low cycles", busy_low, 2);
        tick();
        check("held idle busy", busy, 0);
        check("held read_count", read_count, 6);
        check("held write_count", write_count, 3);

        // Reset during BUSY aborts the response but keeps the written word.
        prop_address    = 32'd20;
        prop_write_en   = 1'b1;
        prop_write_data = 32'h77;
        tick();
        check("abort busy", busy, 1);
        prop_write_en = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_zero("abort");
        nvalid = 0;
        for (int s = 0; s < 5; s++) begin
            tick();
            if (ram_valid) nvalid++;
        end
        check("abort no valid", nvalid, 0);
        xact(32'd20, 1'b1, 1'b0, 32'h0, "rd20");
        check("rd20 data0", ram_data[0], 32'h77);
        check("rd20 read_count", read_count, 1);
        check("rd20 write_count", write_count, 0);

        // Read and write together act as a write.
        xact(32'd5, 1'b1, 1'b1, 32'h12, "rw5");
        check("rw5 write_count", write_count, 1);
        check("rw5 read_count", read_count, 1);
        check("rw5 data0", ram_data[0], 0);
        check("rw5 data1", ram_data[1], 32'h12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
